// File: rtl/mem_pkg.sv
// Shared definitions for the RAM-side access controller: RAM geometry and
// the transaction FSM state encoding.
package mem_pkg;

    // RAM geometry: 512 words of 32 bits.
    localparam int MEM_ADDR_WIDTH = 9;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_DEPTH      = 512;

    // Transaction FSM states. The numeric values are visible on the debug
    // state output, so keep them stable.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } mem_state_e;

    // True for every state in which a transaction is in flight.
    function automatic logic state_is_busy(input mem_state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/mem_bus_reg.sv
// Loadable register with synchronous clear and two load sources.
// Source B has priority over source A; clear has priority over both.
module mem_bus_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             load_a_i,
    input  logic [WIDTH-1:0] data_a_i,
    input  logic             load_b_i,
    input  logic [WIDTH-1:0] data_b_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: hold unless one of the load strobes is active.
    always_comb begin
        value_d = value_q;
        if (load_b_i) begin
            value_d = data_b_i;
        end else if (load_a_i) begin
            value_d = data_a_i;
        end
    end

    // Storage with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign q_o = value_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Bus-side initiator for the synchronous 512x32 RAM. Holds MAR and MDR,
// loads them from the CPU bus while idle, and runs single read or write
// transactions with a start/busy/done handshake.
//
// Handshake: a start is accepted only on an edge where the controller is
// IDLE. busy is high from the cycle after acceptance up to and including the
// done cycle; done is a one-cycle pulse. Starts and loads seen while busy
// (including during DONE) are dropped, not queued. start_read wins over
// start_write when both are high.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  mar_in,
    input  logic                  mdr_in,
    input  logic                  start_read,
    input  logic                  start_write,
    output logic [DATA_WIDTH-1:0] mdr_value,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [2:0]            state_dbg
);

    mem_state_e state_q;
    logic       busy_q;
    logic       done_q;
    logic       ram_read_q;
    logic       ram_write_q;

    logic                  idle;
    logic                  mar_load;
    logic                  mdr_load;
    logic                  mdr_capture;
    logic [ADDR_WIDTH-1:0] mar_q;
    logic [DATA_WIDTH-1:0] mdr_q;

    // Bus bits above the RAM address width are deliberately discarded.
    logic unused_bus_hi;
    assign unused_bus_hi = ^bus_in[DATA_WIDTH-1:ADDR_WIDTH];

    assign idle        = (state_q == IDLE);
    assign mar_load    = idle && mar_in;
    assign mdr_load    = idle && mdr_in;
    // MDR takes the RAM output on the edge that leaves RD_WAIT.
    assign mdr_capture = (state_q == RD_WAIT);

    mem_bus_reg #(
        .WIDTH(ADDR_WIDTH)
    ) u_mar (
        .clk_i   (clock),
        .clear_i (clear),
        .load_a_i(mar_load),
        .data_a_i(bus_in[ADDR_WIDTH-1:0]),
        .load_b_i(1'b0),
        .data_b_i('0),
        .q_o     (mar_q)
    );

    mem_bus_reg #(
        .WIDTH(DATA_WIDTH)
    ) u_mdr (
        .clk_i   (clock),
        .clear_i (clear),
        .load_a_i(mdr_load),
        .data_a_i(bus_in),
        .load_b_i(mdr_capture),
        .data_b_i(ram_data_in),
        .q_o     (mdr_q)
    );

    // Transaction FSM with registered Moore outputs that track the state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_read) begin
                        state_q     <= RD_ADDR;
                        busy_q      <= state_is_busy(RD_ADDR);
                        done_q      <= 1'b0;
                        ram_read_q  <= 1'b1;
                        ram_write_q <= 1'b0;
                    end else if (start_write) begin
                        state_q     <= WR;
                        busy_q      <= state_is_busy(WR);
                        done_q      <= 1'b0;
                        ram_read_q  <= 1'b0;
                        ram_write_q <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b0;
                        ram_read_q  <= 1'b0;
                        ram_write_q <= 1'b0;
                    end
                end
                RD_ADDR: begin
                    state_q     <= RD_WAIT;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                end
                RD_WAIT: begin
                    state_q     <= DONE;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b1;
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                end
                WR: begin
                    state_q     <= DONE;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b1;
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                end
                DONE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign ram_read     = ram_read_q;
    assign ram_write    = ram_write_q;
    assign ram_address  = mar_q;
    assign ram_data_out = mdr_q;
    assign mdr_value    = mdr_q;
    assign state_dbg    = state_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Bus-side initiator for the synchronous 512x32 RAM. It holds the memory address register (MAR) and memory data register (MDR), loads both from the CPU bus, and runs single read/write transactions against the RAM's read/write/address/data pins with a start/busy/done handshake toward the control unit. It sits between the datapath bus and the RAM; the control unit never drives RAM pins directly.

Parameters:
ADDR_WIDTH, 9, RAM address width; MAR takes bus_in[ADDR_WIDTH-1:0]
DATA_WIDTH, 32, bus/RAM word width

Ports:
clock  input  1  system clock, all state updates on rising edge
clear  input  1  synchronous, active-high reset
bus_in  input  DATA_WIDTH  CPU bus value
mar_in  input  1  load MAR from bus_in (idle only)
mdr_in  input  1  load MDR from bus_in (idle only)
start_read  input  1  request RAM read at MAR into MDR
start_write  input  1  request RAM write of MDR to MAR
mdr_value  output  DATA_WIDTH  current MDR contents (to bus mux)
busy  output  1  transaction in progress (any non-IDLE state)
done  output  1  one-cycle completion pulse
ram_read  output  1  to RAM read
ram_write  output  1  to RAM write
ram_address  output  ADDR_WIDTH  to RAM address, always equals MAR
ram_data_out  output  DATA_WIDTH  to RAM data input, always equals MDR
ram_data_in  input  DATA_WIDTH  from RAM data output (registered inside RAM)

Behaviour:
- Interface: single clock `clock`; reset `clear` is synchronous and active-high.
- Reset (clear=1 at an edge): state=IDLE, MAR=0, MDR=0; hence busy=0, done=0, ram_read=0, ram_write=0, ram_address=0, ram_data_out=0. clear overrides all other inputs, including mid-transaction: a pending write is dropped (ram_write low after that edge) and a pending read never updates MDR.
- FSM states: IDLE, RD_ADDR, RD_WAIT, WR, DONE. Moore outputs decoded from the state register only.
- IDLE: mar_in loads MAR; mdr_in loads MDR; both may load on the same edge. start_read -> RD_ADDR. start_write -> WR. If both are high, the read wins and the write is discarded. A load and a start on the same edge: the load takes effect and the transaction uses the new value.
- RD_ADDR: ram_read=1. The RAM registers memory[MAR] at the end of this cycle. Next state is RD_WAIT.
- RD_WAIT: ram_read=0. At the edge, MDR <= ram_data_in. Next state is DONE.
- WR: ram_write=1 for exactly one cycle. The RAM stores MDR at MAR at the closing edge. Next state is DONE.
- DONE: done=1, busy=1. Next state is IDLE unconditionally.
- Latency, counted from the accepting edge E0:
  - Read: done is high in the cycle after E2, and MDR is valid from E2.
  - Write: done is high in the cycle after E1, and RAM is updated at E1.
- While busy: mar_in, mdr_in, start_read and start_write are ignored, not queued. MAR and MDR are frozen except for the RD_WAIT capture.
- ram_read and ram_write are never high together. Neither is high outside RD_ADDR/WR.
- Address width: bus_in upper bits above ADDR_WIDTH are discarded. There is no wrap or bounds error; all 512 addresses are valid.
- Back-to-back: a start asserted during DONE is ignored. The earliest next accept is the first IDLE cycle.

Decomposition:
- Shared package mem_pkg holds:
  - the state encoding localparams: IDLE=0, RD_ADDR=1, RD_WAIT=2, WR=3, DONE=4, 3 bits;
  - the RAM geometry constants: ADDR_WIDTH=9, DATA_WIDTH=32, depth 512.
- One natural sub-module: mem_bus_reg, a loadable register with synchronous clear, instantiated twice for MAR and MDR. The MDR instance has a second load source for read capture.
- FSM and output decode stay in mem_access_ctrl.

Test Plan:
- Read: RAM preloaded with memory[149]=0x000000FF. Apply bus_in=0x95 with mar_in, then start_read. Required: ram_read high for 1 cycle with ram_address=0x095; done pulses in the 3rd cycle after accept; mdr_value=0x000000FF; busy=1 for 3 cycles.
- Write then readback: MAR=0x1F5, MDR=0xDEADBEEF, start_write. Required: ram_write high 1 cycle with ram_data_out=0xDEADBEEF; done 2 cycles after accept. Then load MDR=0 and start_read at 0x1F5: mdr_value=0xDEADBEEF.
- Truncation and simultaneous start: bus_in=0x00000295 with mar_in gives ram_address=0x095. start_read=start_write=1 gives only ram_read pulsing, memory unchanged.
- Busy ignore: during RD_WAIT, pulse mdr_in with bus_in=0x12345678 and start_write. Required: MDR holds the RAM data, no ram_write, a single done pulse.
- Clear mid-write: assert clear in the WR cycle with MAR=20, MDR=0x11. Required: after the edge, ram_write=0, busy=0, done=0, MAR=MDR=0, and no spurious done afterwards.
- Reset values: clear held 2 cycles from power-up. Required: all outputs 0; the first start_read after release reads address 0 (memory[0]=0x01800095 into MDR).
